// File: rtl/sync_fifo_vr_pkg.sv
// Shared constants and width helpers for the sync_fifo_vr FIFO.
// The optional high-watermark output is enabled with SYNC_FIFO_PEAK_EN.

`ifndef SYNC_FIFO_VR_CLOG2
// Ceiling log2 for tools without $clog2 support; swap the body if needed.
`define SYNC_FIFO_VR_CLOG2(x) ($clog2(x))
`endif

package sync_fifo_vr_pkg;

    // Default payload width and storage depth.
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DEPTH     = 16;

    // Default watermarks; almost_full defaults to two below full.
    localparam int DEF_AE_THRESH = 2;
    localparam int DEF_AF_MARGIN = 2;

    // Address width for a given power-of-two depth.
    function automatic int addr_w(input int depth);
        return `SYNC_FIFO_VR_CLOG2(depth);
    endfunction

    // Occupancy width: one extra bit so that DEPTH itself is representable.
    function automatic int cnt_w(input int depth);
        return addr_w(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_vr_if.sv
// Valid/ready handshake bundle for sync_fifo_vr: write side (s_*) and read side (m_*).
// The FIFO takes the slave modport, the surrounding producer/consumer the master one.

interface sync_fifo_vr_if
    import sync_fifo_vr_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;

    // Environment side: offers write data and accepts read data.
    modport master (
        output s_valid,
        output s_data,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  m_data
    );

    // FIFO side.
    modport slave (
        input  s_valid,
        input  s_data,
        input  m_ready,
        output s_ready,
        output m_valid,
        output m_data
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read.
// Read is combinational so the FIFO head appears in the cycle after its write.

module sync_fifo_mem
    import sync_fifo_vr_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int AW    = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write the addressed entry on an accepted push.
    // NOTE: storage has no reset; validity is tracked by the pointers and
    // count, and non-blocking assignment keeps the write race-free against readers.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_vr.sv
// Synchronous valid/ready FIFO with occupancy count and watermark flags.
// Define SYNC_FIFO_PEAK_EN to add the 'peak' high-watermark output.

module sync_fifo_vr
    import sync_fifo_vr_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - DEF_AF_MARGIN,
    parameter int AE_THRESH = DEF_AE_THRESH,
    localparam int AW       = addr_w(DEPTH),
    localparam int CW       = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    sync_fifo_vr_if.slave bus,
    output logic [CW-1:0] count,
    output logic          almost_full,
    output logic          almost_empty
`ifdef SYNC_FIFO_PEAK_EN
    ,
    output logic [CW-1:0] peak
`endif
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;

    // Handshake readiness comes only from the registered count, so neither
    // s_ready nor m_valid depends combinationally on any input.
    assign bus.s_ready = (count != CW'(DEPTH));
    assign bus.m_valid = (count != '0);

    assign push = bus.s_valid & bus.s_ready;
    assign pop  = bus.m_valid & bus.m_ready;

    // Status flags decoded from the registered count.
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    // Next occupancy: flush wins, otherwise +1/-1 on a lone push/pop.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
    end

    // Pointer and count registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
        end
    end

`ifdef SYNC_FIFO_PEAK_EN
    // High-watermark of occupancy since the last reset or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak <= '0;
        end else if (flush) begin
            peak <= '0;
        end else if (count_next > peak) begin
            peak <= count_next;
        end
    end
`endif

    // Storage; a push in a flush cycle is discarded, so the write is gated too.
    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wr_ptr),
        .wdata (bus.s_data),
        .raddr (rd_ptr),
        .rdata (bus.m_data)
    );

endmodule
